// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hold/flush sequencing for the five-stage pipe, shared SRAM
// arbitration (IF vs MEM), load-use bubbles and taken-branch flushes.
// Optional perf counters are built when HAZARD_CTRL_PERF_EN is defined.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_use1/2, id_src1/2      ID-stage source usage and register addresses
//   ex_mem_read, ex_reg_write EXE instruction is a load / writes a register
//   ex_reg_addr               EXE destination register
//   mem_req                   MEM-stage instruction accesses the SRAM
//   branch_taken              EXE resolved a taken branch or jump
//   hold_*                    freeze PC, IF/ID, ID/EXE, EXE/MEM
//   flush_if_id, flush_id_exe load a bubble into IF/ID, ID/EXE
//   pc_redirect               PC loads the branch target
//   if_grant                  IF owns the SRAM this cycle
//   stall_cycles, flush_count perf counters (0 when not built)
package hazard_pkg;
    typedef logic [4:0] RegAddr;
endpackage

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_use1,
    input  logic        id_use2,
    input  RegAddr      id_src1,
    input  RegAddr      id_src2,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  RegAddr      ex_reg_addr,
    input  logic        mem_req,
    input  logic        branch_taken,
    output logic        hold_pc,
    output logic        hold_if_id,
    output logic        hold_id_exe,
    output logic        hold_ex_mem,
    output logic        flush_if_id,
    output logic        flush_id_exe,
    output logic        pc_redirect,
    output logic        if_grant,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic {
        RUN,
        MEM_BUSY
    } state_t;

    // Cycles left after the one entering MEM_BUSY.
    localparam logic [3:0] CNT_INIT =
        (MEM_CYCLES > 1) ? 4'(MEM_CYCLES - 2) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       br_pending;
    logic       br_pending_nxt;
    logic       load_use;
    logic       br_any;

    assign load_use = ex_mem_read & ex_reg_write &
                      ((id_use1 & (id_src1 == ex_reg_addr)) |
                       (id_use2 & (id_src2 == ex_reg_addr)));

    // A branch seen while frozen is replayed from br_pending.
    assign br_any = branch_taken | br_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= 4'd0;
            br_pending <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            br_pending <= br_pending_nxt;
        end
    end

    always_comb begin
        hold_pc        = 1'b0;
        hold_if_id     = 1'b0;
        hold_id_exe    = 1'b0;
        hold_ex_mem    = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_exe   = 1'b0;
        pc_redirect    = 1'b0;
        if_grant       = 1'b1;
        state_nxt      = state;
        cnt_nxt        = cnt;
        br_pending_nxt = br_pending;
        if (rst) begin
            flush_if_id  = 1'b1;
            flush_id_exe = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && (MEM_CYCLES > 1)) begin
                        hold_pc     = 1'b1;
                        hold_if_id  = 1'b1;
                        hold_id_exe = 1'b1;
                        hold_ex_mem = 1'b1;
                        if_grant    = 1'b0;
                        state_nxt   = MEM_BUSY;
                        cnt_nxt     = CNT_INIT;
                        if (branch_taken) br_pending_nxt = 1'b1;
                    end else if (mem_req) begin
                        // Single-cycle access: the fetch slot is lost.
                        if_grant = 1'b0;
                        if (br_any) begin
                            pc_redirect    = 1'b1;
                            flush_if_id    = 1'b1;
                            flush_id_exe   = 1'b1;
                            br_pending_nxt = 1'b0;
                        end else begin
                            hold_pc     = 1'b1;
                            flush_if_id = 1'b1;
                        end
                    end else if (br_any) begin
                        pc_redirect    = 1'b1;
                        flush_if_id    = 1'b1;
                        flush_id_exe   = 1'b1;
                        br_pending_nxt = 1'b0;
                    end else if (load_use) begin
                        hold_pc      = 1'b1;
                        hold_if_id   = 1'b1;
                        flush_id_exe = 1'b1;
                    end
                end
                MEM_BUSY: begin
                    if_grant = 1'b0;
                    if (cnt != 4'd0) begin
                        hold_pc     = 1'b1;
                        hold_if_id  = 1'b1;
                        hold_id_exe = 1'b1;
                        hold_ex_mem = 1'b1;
                        cnt_nxt     = cnt - 4'd1;
                        if (branch_taken) br_pending_nxt = 1'b1;
                    end else begin
                        // Final access cycle: EXE/MEM advances.
                        state_nxt = RUN;
                        if (br_any) begin
                            pc_redirect    = 1'b1;
                            flush_if_id    = 1'b1;
                            flush_id_exe   = 1'b1;
                            br_pending_nxt = 1'b0;
                        end else begin
                            hold_pc     = 1'b1;
                            flush_if_id = 1'b1;
                        end
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
            flush_q <= 16'd0;
        end else begin
            if (hold_pc)      stall_q <= stall_q + 32'd1;
            if (flush_id_exe) flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 16'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It owns the `hold`/`flush` controls of the PC, IF/ID, ID/EXE and EXE/MEM registers. It arbitrates the single shared SRAM between instruction fetch and the MEM stage, inserts load-use bubbles, and applies taken-branch flushes, including branches that resolve while the pipe is frozen.

## Interface
Parameters:
- `MEM_CYCLES`, default 2: SRAM data-access length in cycles. Legal range is 1..15.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous reset, active-high.
- `id_use1`, `id_use2`  in  1 each  ID-stage instruction reads source 1 / source 2.
- `id_src1`, `id_src2`  in  `RegAddr` each  ID-stage source register addresses.
- `ex_mem_read`  in  1  instruction in EXE is a load (ID/EXE `mem_read_out`).
- `ex_reg_write`  in  1  EXE instruction writes a register.
- `ex_reg_addr`  in  `RegAddr`  EXE destination register.
- `mem_req`  in  1  MEM-stage instruction accesses SRAM (load or store).
- `branch_taken`  in  1  EXE resolved a taken branch or jump.
- `hold_pc`, `hold_if_id`, `hold_id_exe`, `hold_ex_mem`  out  1 each  freeze the named register.
- `flush_if_id`, `flush_id_exe`  out  1 each  load a NOP bubble into the named register.
- `pc_redirect`  out  1  PC loads the branch target this cycle.
- `if_grant`  out  1  IF owns the SRAM this cycle.
- `stall_cycles`  out  32  perf counter; see Configuration.
- `flush_count`  out  16  perf counter; see Configuration.

## Operation
- Internal state:
  - FSM `RUN`/`MEM_BUSY`.
  - 4-bit down-counter `cnt`.
  - Flag `br_pending`.
- Outputs are combinational from the state and the inputs. Any output not asserted by a rule below is 0, except `if_grant`, which defaults to 1.
- The "hold cycle" flag is high whenever `hold_id_exe` is 1.

`RUN`, evaluated in priority order:
1. `mem_req` with `MEM_CYCLES>1`:
   - Assert `hold_pc`, `hold_if_id`, `hold_id_exe`, `hold_ex_mem`.
   - Drive `if_grant=0`.
   - Next state `MEM_BUSY`, `cnt<=MEM_CYCLES-2`.
   - If `branch_taken` is also high, set `br_pending`.
2. `mem_req` with `MEM_CYCLES==1`:
   - Drive `if_grant=0`.
   - Assert `hold_pc` and `flush_if_id` (the fetch slot is lost).
   - Apply rule 3 if a branch is active.
3. `branch_taken` or `br_pending`:
   - Assert `pc_redirect`, `flush_if_id`, `flush_id_exe`.
   - Clear `br_pending`.
   - In this case `hold_pc` is forced 0 so the redirect loads.
4. Load-use: `ex_mem_read & ex_reg_write & ((id_use1 & id_src1==ex_reg_addr) | (id_use2 & id_src2==ex_reg_addr))`:
   - Assert `hold_pc`, `hold_if_id`, `flush_id_exe` for this cycle only.

`MEM_BUSY`:
- `if_grant=0` throughout.
- While `cnt!=0`:
  - All four holds are 1.
  - `cnt` decrements.
  - `branch_taken` sets `br_pending`.
- On `cnt==0` (final access cycle):
  - `hold_pc=1`, `flush_if_id=1`.
  - `hold_id_exe` and `hold_ex_mem` are 0.
  - If `br_pending | branch_taken`: apply rule 3 instead; the redirect overrides `hold_pc`.
  - Next state `RUN`.

Invariants:
- Hold and flush are never both 1 on the same register.
- No flush or redirect is ever issued in a hold cycle.
- `branch_taken` seen in a hold cycle is never lost.

## Timing
- Reset, while `rst=1`:
  - All holds are 0; `flush_if_id=1`, `flush_id_exe=1`.
  - `pc_redirect=0`, `if_grant=1`.
  - Next state `RUN`, `cnt=0`, `br_pending=0`.
  - Reset during `MEM_BUSY` aborts the access.
- Load-use costs exactly 1 bubble.
- A data access freezes EXE/MEM for `MEM_CYCLES-1` cycles and costs IF `MEM_CYCLES` fetch slots.
- `mem_req` staying high in the final `MEM_BUSY` cycle does not retrigger. A new access starts only from `RUN`.
- Back-to-back accesses: `RUN` re-enters `MEM_BUSY` on the next cycle with no gap.

## Configuration
- `HAZARD_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every cycle with `hold_pc=1`.
  - `flush_count` increments on every cycle with `flush_id_exe=1`.
  - Both counters wrap and clear on `rst`.
- Not defined: both counters are tied to 0 and no counter flops exist.

## Test plan
- Load-use, `MEM_CYCLES=2`:
  - Stimulus: `ex_mem_read=1`, `ex_reg_write=1`, `ex_reg_addr=3`, `id_use1=1`, `id_src1=3`.
  - Required: one cycle of `hold_pc=hold_if_id=flush_id_exe=1`.
  - Same stimulus with `id_src1=4`: all outputs 0.
- Data access, `MEM_CYCLES=3`, `mem_req` held high for 3 cycles:
  - Cycles 1-2: all holds 1, `if_grant=0`.
  - Cycle 3: `hold_pc=flush_if_id=1`, `hold_id_exe=0`, `if_grant=0`.
  - Cycle 4: `if_grant=1`.
- Branch in `RUN`: `branch_taken=1` for 1 cycle -> `pc_redirect=flush_if_id=flush_id_exe=1` that cycle only.
- Branch during access, `MEM_CYCLES=3`:
  - Stimulus: `branch_taken` pulses in cycle 2.
  - Required: no flush in cycles 1-2; cycle 3 gives `pc_redirect=flush_if_id=flush_id_exe=1`, `hold_pc=0`; `br_pending=0` afterwards.
- Reset mid-access: `rst` in `MEM_BUSY` cycle 2 -> next cycle in `RUN`, `if_grant=1`, holds 0.
- Perf counters, `HAZARD_CTRL_PERF_EN` defined:
  - Stimulus: one load-use, then one `MEM_CYCLES=3` access.
  - Required: `stall_cycles=4`, `flush_count=1`.
  - Without the macro: both counters read 0.
